// File: rtl/ad_rx_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module : ad_rx_pattern_gen
// Brief  : RX interface beat generator (ramp / PN9 / constant / zero frames)
// Rev    : 1.0
// ============================================================================
module ad_rx_pattern_gen #(
  parameter int DATA_WIDTH   = 6,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [2*DATA_WIDTH-1:0] const_i,
  input  logic [2*DATA_WIDTH-1:0] const_q,
  output logic                    rx_frame,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    rx_valid,
  output logic                    busy,
  output logic [15:0]             frame_cnt
);

  localparam int SAMPLE_WIDTH = 2*DATA_WIDTH;
  localparam int FRAME_BEATS  = 4*NUM_CHANNELS;
  localparam int BW           = $clog2(FRAME_BEATS);

  localparam logic [BW-1:0] LAST_BEAT  = BW'(FRAME_BEATS-1);
  localparam logic [BW-1:0] HALF_BEATS = BW'(2*NUM_CHANNELS);
  localparam logic [8:0]    LFSR_SEED  = 9'h1FF;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_PN9   = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;
  localparam logic [1:0] MODE_ZERO  = 2'd3;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [SAMPLE_WIDTH-1:0] ramp_q, ramp_d;
  logic [8:0]              lfsr_q, lfsr_d;
  logic [1:0]              mode_q, mode_d;
  logic [SAMPLE_WIDTH-1:0] ci_q, ci_d, cq_q, cq_d;
  logic                    rx_frame_q, rx_frame_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    busy_q, busy_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;

  logic                    w_start, w_last, w_new_frame, w_stop, w_emit;
  logic [8:0]              w_lfsr_base;
  logic [SAMPLE_WIDTH-1:0] w_chan, w_samp_i, w_samp_q;

  always_comb begin
    w_start     = (state_q == IDLE) && enable;
    w_last      = (state_q == RUN) && (beat_q == LAST_BEAT);
    w_new_frame = w_start || (w_last && enable);
    w_stop      = w_last && !enable;
    w_emit      = w_start || ((state_q == RUN) && !w_stop);
    w_lfsr_base = w_start ? LFSR_SEED : lfsr_q;

    state_d     = state_q;
    beat_d      = beat_q;
    ramp_d      = ramp_q;
    lfsr_d      = lfsr_q;
    mode_d      = mode_q;
    ci_d        = ci_q;
    cq_d        = cq_q;
    frame_cnt_d = frame_cnt_q;

    if (w_stop) begin
      state_d = IDLE;
    end else if (w_start) begin
      state_d = RUN;
    end

    // Pattern controls are latched only at a frame's first beat
    if (w_new_frame) begin
      beat_d = '0;
      mode_d = mode;
      ci_d   = const_i;
      cq_d   = const_q;
    end else if (w_emit) begin
      beat_d = beat_q + BW'(1);
    end

    if (w_start) begin
      ramp_d = '0;
    end else if (w_last) begin
      ramp_d = ramp_q + SAMPLE_WIDTH'(1);
    end

    if (w_emit) begin
      lfsr_d = {w_lfsr_base[7:0], w_lfsr_base[8] ^ w_lfsr_base[4]};
    end

    w_chan = SAMPLE_WIDTH'(beat_d >> 2);
    case (mode_d)
      MODE_RAMP: begin
        w_samp_i = ramp_d + w_chan;
        w_samp_q = ~w_samp_i;
      end
      MODE_CONST: begin
        w_samp_i = ci_d;
        w_samp_q = cq_d;
      end
      default: begin
        w_samp_i = '0;
        w_samp_q = '0;
      end
    endcase

    case (beat_d[1:0])
      2'd0:    rx_data_d = w_samp_i[SAMPLE_WIDTH-1:DATA_WIDTH];
      2'd1:    rx_data_d = w_samp_i[DATA_WIDTH-1:0];
      2'd2:    rx_data_d = w_samp_q[SAMPLE_WIDTH-1:DATA_WIDTH];
      default: rx_data_d = w_samp_q[DATA_WIDTH-1:0];
    endcase
    if (mode_d == MODE_PN9) begin
      rx_data_d = lfsr_d[DATA_WIDTH-1:0];
    end else if (mode_d == MODE_ZERO) begin
      rx_data_d = '0;
    end

    rx_frame_d = beat_d < HALF_BEATS;
    rx_valid_d = w_emit;
    busy_d     = w_emit;
    if (!w_emit) begin
      rx_frame_d = 1'b0;
      rx_data_d  = '0;
    end

    if (w_emit && (beat_d == LAST_BEAT)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      ramp_q      <= '0;
      lfsr_q      <= LFSR_SEED;
      mode_q      <= MODE_RAMP;
      ci_q        <= '0;
      cq_q        <= '0;
      rx_frame_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      ramp_q      <= ramp_d;
      lfsr_q      <= lfsr_d;
      mode_q      <= mode_d;
      ci_q        <= ci_d;
      cq_q        <= cq_d;
      rx_frame_q  <= rx_frame_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rx_frame  = rx_frame_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ad_rx_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_ad_rx_pattern_gen
// Brief  : Scoreboard bench running NC=1 and NC=2 generators side by side
// Rev    : 1.0
// ============================================================================
module tb_ad_rx_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] const_i = 12'h000;
  logic [11:0] const_q = 12'h000;

  logic        f1, v1, b1, f2, v2, b2;
  logic [5:0]  d1, d2;
  logic [15:0] fc1_o, fc2_o;

  always #5 clk = ~clk;

  ad_rx_pattern_gen #(.DATA_WIDTH(6), .NUM_CHANNELS(1)) u_nc1 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .const_i(const_i), .const_q(const_q),
    .rx_frame(f1), .rx_data(d1), .rx_valid(v1), .busy(b1), .frame_cnt(fc1_o)
  );

  ad_rx_pattern_gen #(.DATA_WIDTH(6), .NUM_CHANNELS(2)) u_nc2 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .const_i(const_i), .const_q(const_q),
    .rx_frame(f2), .rx_data(d2), .rx_valid(v2), .busy(b2), .frame_cnt(fc2_o)
  );

  logic [6:0] q1[$];
  logic [6:0] q2[$];
  logic [6:0] e1, e2;
  int n_total = 0;
  int n_pass  = 0;
  int fc1 = 0;
  int fc2 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected beats of one frame (ramp / constant / zero) queued per DUT
  task automatic push_frame(input int nc, input logic [1:0] m, input logic [11:0] base,
                            input logic [11:0] ci, input logic [11:0] cq, input int nbeats);
    logic [11:0] si, sq;
    logic [5:0]  d;
    logic        fr;
    for (int b = 0; b < nbeats; b++) begin
      case (m)
        2'd0:    begin si = base + 12'(b / 4); sq = ~si; end
        2'd2:    begin si = ci; sq = cq; end
        default: begin si = 12'h000; sq = 12'h000; end
      endcase
      case (b % 4)
        0:       d = si[11:6];
        1:       d = si[5:0];
        2:       d = sq[11:6];
        default: d = sq[5:0];
      endcase
      fr = (b < 2 * nc);
      if (nc == 1) q1.push_back({fr, d});
      else         q2.push_back({fr, d});
    end
    if (nbeats == 4 * nc) begin
      if (nc == 1) fc1++;
      else         fc2++;
    end
  endtask

  task automatic push_lit(input int nc, input logic [5:0] d, input logic fr);
    if (nc == 1) q1.push_back({fr, d});
    else         q2.push_back({fr, d});
  endtask

  task automatic run(input int n);
    enable = 1'b1;
    repeat (n) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    check({tag, " nc1 frame_cnt"}, 32'(fc1_o), 32'(16'(fc1)));
    check({tag, " nc2 frame_cnt"}, 32'(fc2_o), 32'(16'(fc2)));
  endtask

  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) check("nc1 unexpected beat (queue depth)", q1.size(), 1);
      else begin
        e1 = q1.pop_front();
        check("nc1 beat {busy,frame,data}", {b1, f1, d1}, {1'b1, e1});
      end
    end else begin
      check("nc1 idle {busy,frame,data}", {b1, f1, d1}, 8'h00);
    end
    if (v2) begin
      if (q2.size() == 0) check("nc2 unexpected beat (queue depth)", q2.size(), 1);
      else begin
        e2 = q2.pop_front();
        check("nc2 beat {busy,frame,data}", {b2, f2, d2}, {1'b1, e2});
      end
    end else begin
      check("nc2 idle {busy,frame,data}", {b2, f2, d2}, 8'h00);
    end
  end

  logic [5:0] ramp0_nc2 [8];
  logic [5:0] pn_seq [8];
  logic [5:0] cst [4];

  initial begin
    ramp0_nc2 = '{6'h00, 6'h00, 6'h3F, 6'h3F, 6'h00, 6'h01, 6'h3F, 6'h3E};
    pn_seq    = '{6'h3E, 6'h3C, 6'h38, 6'h30, 6'h20, 6'h01, 6'h03, 6'h07};
    cst       = '{6'h29, 6'h1C, 6'h04, 6'h23};

    repeat (2) @(negedge clk);
    check("reset nc1 outputs", {f1, v1, b1, d1, fc1_o}, 0);
    check("reset nc2 outputs", {f2, v2, b2, d2, fc2_o}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Ramp, enable held for two NC=2 frames
    mode = 2'd0;
    for (int b = 0; b < 8; b++) push_lit(2, ramp0_nc2[b], b < 4);
    fc2++;
    push_frame(2, 2'd0, 12'h001, 12'h000, 12'h000, 8);
    for (int r = 0; r < 4; r++) push_frame(1, 2'd0, 12'(r), 12'h000, 12'h000, 4);
    run(16);
    check_counts("ramp");

    // Constant mode, frame counter stepping every 4 beats on NC=1
    mode = 2'd2; const_i = 12'hA5C; const_q = 12'h123;
    for (int b = 0; b < 8; b++) push_lit(1, cst[b % 4], (b % 4) < 2);
    for (int b = 0; b < 8; b++) push_lit(2, cst[b % 4], b < 4);
    fc1 += 2; fc2++;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("const nc1 frame_cnt before last beat", 32'(fc1_o), 32'(16'(fc1 - 2)));
    @(negedge clk);
    check("const nc1 frame_cnt after 4 beats", 32'(fc1_o), 32'(16'(fc1 - 1)));
    repeat (4) @(negedge clk);
    check("const nc1 frame_cnt after 8 beats", 32'(fc1_o), 32'(16'(fc1)));
    enable = 1'b0;
    @(negedge clk);
    check_counts("const");

    // PN9 from seed
    mode = 2'd1;
    for (int b = 0; b < 8; b++) push_lit(1, pn_seq[b], (b % 4) < 2);
    for (int b = 0; b < 8; b++) push_lit(2, pn_seq[b], b < 4);
    fc1 += 2; fc2++;
    run(8);
    check_counts("pn9");

    // Stop requested at beat 2: current frame completes
    mode = 2'd0;
    push_frame(2, 2'd0, 12'h000, 12'h000, 12'h000, 8);
    push_frame(1, 2'd0, 12'h000, 12'h000, 12'h000, 4);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check("stop nc2 valid/busy", {v2, b2}, 2'b00);
    check_counts("stop");

    // Stop request cancelled before the frame ends
    push_frame(2, 2'd0, 12'h000, 12'h000, 12'h000, 8);
    push_frame(2, 2'd0, 12'h001, 12'h000, 12'h000, 8);
    for (int r = 0; r < 4; r++) push_frame(1, 2'd0, 12'(r), 12'h000, 12'h000, 4);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_counts("cancel");

    // Mode change mid-frame applies from the next frame
    mode = 2'd2;
    push_frame(2, 2'd2, 12'h000, 12'hA5C, 12'h123, 8);
    push_frame(1, 2'd2, 12'h000, 12'hA5C, 12'h123, 4);
    push_frame(1, 2'd3, 12'h000, 12'hA5C, 12'h123, 4);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    mode = 2'd3;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_counts("mode change");

    // Asynchronous reset at beat 5, then restart from ramp 0
    mode = 2'd0;
    push_frame(2, 2'd0, 12'h000, 12'h000, 12'h000, 6);
    push_frame(1, 2'd0, 12'h000, 12'h000, 12'h000, 4);
    push_frame(1, 2'd0, 12'h001, 12'h000, 12'h000, 2);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async reset nc1 outputs", {f1, v1, b1, d1, fc1_o}, 0);
    check("async reset nc2 outputs", {f2, v2, b2, d2, fc2_o}, 0);
    enable = 1'b0;
    fc1 = 0; fc2 = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post-reset idle busy", {b1, b2}, 2'b00);
    push_frame(2, 2'd0, 12'h000, 12'h000, 12'h000, 8);
    push_frame(1, 2'd0, 12'h000, 12'h000, 12'h000, 4);
    push_frame(1, 2'd0, 12'h001, 12'h000, 12'h000, 4);
    run(8);
    check_counts("restart");

    // Long ramp run: NC=1 ramp wraps back to 0 at frame 4096
    for (int r = 0; r < 4098; r++) push_frame(1, 2'd0, 12'(r), 12'h000, 12'h000, 4);
    for (int r = 0; r < 2049; r++) push_frame(2, 2'd0, 12'(r), 12'h000, 12'h000, 8);
    run(16392);
    check_counts("wrap");

    check("nc1 scoreboard drained", q1.size(), 0);
    check("nc2 scoreboard drained", q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
